// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - handshake and operand/result bundle for serial_subtractor
//
// Signals:
//   Start    request to begin a subtraction (sampled only while the block is idle)
//   A, B     minuend and subtrahend, captured on the accepting edge
//   Busy     high while bits are being processed
//   Done     one-cycle completion pulse
//   Diff     A-B modulo 2^WIDTH
//   Bout     final borrow (A<B unsigned)
//   Overflow two's-complement overflow of A-B
// master drives the request side, slave is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Overflow;

    modport master (
        output Start, A, B,
        input  Busy, Done, Diff, Bout, Overflow
    );

    modport slave (
        input  Start, A, B,
        output Busy, Done, Diff, Bout, Overflow
    );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A-B subtractor, LSB first, one bit per clock
//
// Ports:
//   Clk      single clock, rising edge
//   Reset_n  asynchronous active-low reset
//   bus      serial_subtractor_if.slave: Start/A/B in, Busy/Done/Diff/Bout/Overflow out
//
// Timing: Start accepted at edge k -> Busy during cycles after edges k..k+WIDTH-1,
// Done during the cycle after edge k+WIDTH, back to IDLE on the following edge.
module serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic                Clk,
    input  logic                Reset_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_q;
    logic             ov_q;

    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs.
    assign a0       = a_sr[0];
    assign b0       = b_sr[0];
    assign d        = a0 ^ b0 ^ br;
    assign br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.Start) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_q <= 1'b0;
            ov_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        a_sr   <= bus.A;
                        b_sr   <= bus.B;
                        res_sr <= '0;
                        cnt    <= '0;
                        br     <= 1'b0;
                        bout_q <= 1'b0;
                        ov_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    res_sr <= {d, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        bout_q <= br_next;
                        // On the last bit a0/b0 are the operand sign bits.
                        ov_q   <= (a0 != b0) && (d != a0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.Busy     = (state == SHIFT);
    assign bus.Done     = (state == DONE);
    assign bus.Diff     = res_sr;
    assign bus.Bout     = bout_q;
    assign bus.Overflow = ov_q;
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width in bits (legal values 2..32).
REQ-002 The block SHALL have port Clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1, the reset: asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1, the request to begin a subtraction; it is sampled only in IDLE.
REQ-005 The block SHALL have port A, input, WIDTH, the minuend; it is captured on the accepting edge.
REQ-006 The block SHALL have port B, input, WIDTH, the subtrahend; it is captured on the accepting edge.
REQ-007 The block SHALL have port Busy, output, 1, which is high while an operation is in SHIFT.
REQ-008 The block SHALL have port Done, output, 1, a one-cycle completion pulse.
REQ-009 The block SHALL have port Diff, output, WIDTH, the result A-B modulo 2^WIDTH.
REQ-010 The block SHALL have port Bout, output, 1, the final borrow; it is 1 when A<B unsigned.
REQ-011 The block SHALL have port Overflow, output, 1, the two's-complement signed overflow of A-B.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with Start=1 at an edge, the block SHALL:
- load A and B into internal shift registers;
- clear the borrow flop and the bit counter;
- enter SHIFT, with Busy=1 from the next cycle.
REQ-014 Each edge in SHIFT SHALL process one bit, LSB first:
- d = a0 XOR b0 XOR br;
- br_next = (NOT a0 AND b0) OR (NOT(a0 XOR b0) AND br);
- d is shifted into the result register at the MSB end;
- both operand registers shift right by one;
- the counter increments.
REQ-015 On the edge that processes bit WIDTH-1, the block SHALL:
- move to DONE;
- latch Bout = br_next;
- latch Overflow = (A[MSB] != B[MSB]) AND (d != A[MSB]).
REQ-016 In DONE, Done SHALL be 1 and Busy SHALL be 0 for exactly one cycle, and the next edge SHALL return the FSM to IDLE unconditionally.
REQ-017 Latency: if Start is accepted at edge k, Done SHALL be high during the cycle following edge k+WIDTH, and Busy SHALL be high only during the cycles following edges k .. k+WIDTH-1.
REQ-018 Diff, Bout and Overflow SHALL be valid when Done=1 and SHALL hold until the next accepted Start; they SHALL NOT be guaranteed during SHIFT.
REQ-019 Start in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 Changes on A or B after the accepting edge SHALL NOT affect the result.
REQ-021 Counter wrap SHALL NOT occur: the counter SHALL be sized for WIDTH and SHALL clear on each accept.
REQ-022 The maximum issue rate SHALL be one operation per WIDTH+2 cycles: Start held high continuously SHALL be re-accepted in IDLE after DONE.

Reset
REQ-023 Reset_n=0 SHALL immediately, without waiting for Clk, force:
- FSM to IDLE;
- Busy=0, Done=0;
- Diff=0, Bout=0, Overflow=0;
- counter, borrow and shift registers to 0.
REQ-024 Reset asserted mid-operation SHALL abort that operation with no Done pulse, either during reset or after its release.
REQ-025 The first Start SHALL be accepted on the first rising edge after Reset_n deasserts.

Verification
REQ-026 With WIDTH=16, A=0x0005, B=0x0003, the bench SHALL see Done 17 cycles after the Start edge, with Diff=0x0002, Bout=0, Overflow=0.
REQ-027 With A=0x0003, B=0x0005, the bench SHALL see Diff=0xFFFE, Bout=1, Overflow=0.
REQ-028 With A=0x8000, B=0x0001, the bench SHALL see Diff=0x7FFF, Bout=0, Overflow=1; with A=0x7FFF, B=0xFFFF, it SHALL see Diff=0x8000, Bout=1, Overflow=1.
REQ-029 A second Start pulse 5 cycles into SHIFT, with different A/B values, SHALL be ignored: the first result is unchanged, there is exactly one Done pulse, and Busy has no gap.
REQ-030 Reset_n pulsed low at cycle 8 of SHIFT SHALL drive all outputs to 0 asynchronously, produce no Done pulse, and a new Start (A=0xFFFF, B=0xFFFF) afterwards SHALL yield Diff=0x0000, Bout=0.
REQ-031 Start held high continuously SHALL produce Done pulses exactly 18 cycles apart.
